// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator with prioritised redirects, a valid/ready
// fetch handshake, stall buffering of redirects and misaligned-target faults.
module pc_gen #(
  parameter int unsigned            XLEN       = 32,
  parameter logic [XLEN-1:0]        PC_INIT    = '0,
  parameter int unsigned            STEP       = 4,
  parameter int unsigned            ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            nrst,
  output logic            fetch_req_valid,
  input  logic            fetch_req_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] pc_add4,
  input  logic            stall,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            ret_en,
  input  logic [XLEN-1:0] ret_addr,
  input  logic            branch_addr_en,
  input  logic [XLEN-1:0] branch_addr,
  output logic            misalign_fault,
  output logic [XLEN-1:0] misalign_addr,
  output logic            pending_valid
);

  // Low address bits that must be zero; all-zero mask disables the check.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_RUN   = 2'b01,
    S_FAULT = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_trap_q, pend_trap_d;
  logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   fault_addr_q, fault_addr_d;

  logic              sel_en_c;
  logic [XLEN-1:0]   sel_addr_c;
  logic              apply_c;
  logic [XLEN-1:0]   tgt_c;

  // Redirect priority: trap > return > branch.
  always_comb begin
    sel_en_c = trap_en | ret_en | branch_addr_en;
    if (trap_en) begin
      sel_addr_c = trap_addr;
    end else if (ret_en) begin
      sel_addr_c = ret_addr;
    end else begin
      sel_addr_c = branch_addr;
    end
  end

  // Next-state, next-PC, pending buffer and fault logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_trap_d  = pend_trap_q;
    pend_addr_d  = pend_addr_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    apply_c      = 1'b0;
    tgt_c        = '0;

    case (state_q)
      S_BOOT, S_RUN: begin
        state_d = S_RUN;
        if (stall) begin
          // A trap already waiting is never displaced by a lower-priority redirect.
          if (sel_en_c && !(pend_valid_q && pend_trap_q && !trap_en)) begin
            pend_valid_d = 1'b1;
            pend_trap_d  = trap_en;
            pend_addr_d  = sel_addr_c;
          end
        end else if (pend_valid_q) begin
          // Older buffered redirect goes first; a new one takes its slot.
          apply_c = 1'b1;
          tgt_c   = pend_addr_q;
          if (sel_en_c) begin
            pend_trap_d = trap_en;
            pend_addr_d = sel_addr_c;
          end else begin
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
          end
        end else if (sel_en_c) begin
          apply_c = 1'b1;
          tgt_c   = sel_addr_c;
        end else if ((state_q == S_RUN) && fetch_req_ready) begin
          pc_d = pc_add4;
        end

        if (apply_c) begin
          if (|(tgt_c & ALIGN_MASK)) begin
            fault_d      = 1'b1;
            fault_addr_d = tgt_c;
            state_d      = S_FAULT;
          end else begin
            pc_d = tgt_c;
          end
        end
      end

      S_FAULT: begin
        // Only a trap can leave the fault state.
        if (trap_en) begin
          if (|(trap_addr & ALIGN_MASK)) begin
            fault_d      = 1'b1;
            fault_addr_d = trap_addr;
          end else begin
            pc_d         = trap_addr;
            state_d      = S_RUN;
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    valid_d = (state_d == S_RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_BOOT;
      pc_q         <= PC_INIT;
      valid_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_trap_q  <= 1'b0;
      pend_addr_q  <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      pend_valid_q <= pend_valid_d;
      pend_trap_q  <= pend_trap_d;
      pend_addr_q  <= pend_addr_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fetch_pc        = pc_q;
  assign pc_add4         = pc_q + XLEN'(STEP);
  assign fetch_req_valid = valid_q;
  assign pending_valid   = pend_valid_q;
  assign misalign_fault  = fault_q;
  assign misalign_addr   = fault_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            fetch_req_valid;
  logic            fetch_req_ready = 1'b0;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_add4;
  logic            stall = 1'b0;
  logic            trap_en = 1'b0;
  logic [XLEN-1:0] trap_addr = '0;
  logic            ret_en = 1'b0;
  logic [XLEN-1:0] ret_addr = '0;
  logic            branch_addr_en = 1'b0;
  logic [XLEN-1:0] branch_addr = '0;
  logic            misalign_fault;
  logic [XLEN-1:0] misalign_addr;
  logic            pending_valid;

  pc_gen dut (
    .clk             (clk),
    .nrst            (nrst),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_pc        (fetch_pc),
    .pc_add4         (pc_add4),
    .stall           (stall),
    .trap_en         (trap_en),
    .trap_addr       (trap_addr),
    .ret_en          (ret_en),
    .ret_addr        (ret_addr),
    .branch_addr_en  (branch_addr_en),
    .branch_addr     (branch_addr),
    .misalign_fault  (misalign_fault),
    .misalign_addr   (misalign_addr),
    .pending_valid   (pending_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural view of the generator.
  typedef struct {
    logic [31:0] addr;
    bit          trap;
  } redir_t;

  redir_t      m_pend[$];
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_faulted;
  bit          m_pulse;
  logic [31:0] m_fault_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] wrap_add(input logic [31:0] a, input int unsigned b);
    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_pc         = 32'h0;
    m_boot       = 1'b1;
    m_faulted    = 1'b0;
    m_pulse      = 1'b0;
    m_fault_addr = 32'h0;
  endtask

  // One clock edge of the model, using the inputs currently driven.
  task automatic model_step();
    bit          any;
    logic [31:0] sel;
    bit          take;
    logic [31:0] tgt;
    redir_t      r;
    any     = trap_en || ret_en || branch_addr_en;
    sel     = trap_en ? trap_addr : (ret_en ? ret_addr : branch_addr);
    r.addr  = sel;
    r.trap  = trap_en;
    take    = 1'b0;
    tgt     = 32'h0;
    m_pulse = 1'b0;
    if (m_faulted) begin
      if (trap_en) begin
        if (trap_addr % 4 != 0) begin
          m_pulse      = 1'b1;
          m_fault_addr = trap_addr;
        end else begin
          m_pc      = trap_addr;
          m_faulted = 1'b0;
          m_pend.delete();
        end
      end
    end else begin
      if (stall) begin
        if (any) begin
          if (m_pend.size() == 0) m_pend.push_back(r);
          else if (!(m_pend[0].trap && !trap_en)) m_pend[0] = r;
        end
      end else if (m_pend.size() != 0) begin
        tgt  = m_pend[0].addr;
        take = 1'b1;
        void'(m_pend.pop_front());
        if (any) m_pend.push_back(r);
      end else if (any) begin
        tgt  = sel;
        take = 1'b1;
      end else if (!m_boot && fetch_req_ready) begin
        m_pc = wrap_add(m_pc, 4);
      end
      m_boot = 1'b0;
      if (take) begin
        if (tgt % 4 != 0) begin
          m_pulse      = 1'b1;
          m_fault_addr = tgt;
          m_faulted    = 1'b1;
        end else begin
          m_pc = tgt;
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pc"},    64'(fetch_pc),        64'(m_pc));
    chk({ctx, ".valid"}, 64'(fetch_req_valid), 64'(!m_boot && !m_faulted));
    chk({ctx, ".add4"},  64'(pc_add4),         64'(wrap_add(m_pc, 4)));
    chk({ctx, ".pend"},  64'(pending_valid),   64'(m_pend.size() != 0));
    chk({ctx, ".flt"},   64'(misalign_fault),  64'(m_pulse));
    chk({ctx, ".faddr"}, 64'(misalign_addr),   64'(m_fault_addr));
  endtask

  // Inputs are stable from the previous falling edge; check after the next one.
  task automatic cycle(input string ctx);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic clear_redirects();
    trap_en        = 1'b0;
    ret_en         = 1'b0;
    branch_addr_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    model_reset();
    fetch_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all("rst");

    // Boot sequence.
    nrst = 1'b1;
    check_all("boot");
    chk("boot_valid", 64'(fetch_req_valid), 64'd0);
    cycle("run0");
    chk("run0_pc", 64'(fetch_pc), 64'h0);
    cycle("run1");
    chk("run1_pc", 64'(fetch_pc), 64'h4);
    cycle("run2");
    chk("run2_pc", 64'(fetch_pc), 64'h8);
    fetch_req_ready = 1'b0;
    cycle("hold0");
    cycle("hold1");
    chk("hold_pc", 64'(fetch_pc), 64'h8);

    // Same-cycle redirects: trap wins.
    trap_en = 1'b1; trap_addr = 32'h100;
    ret_en = 1'b1; ret_addr = 32'h200;
    branch_addr_en = 1'b1; branch_addr = 32'h300;
    cycle("prio");
    chk("prio_pc", 64'(fetch_pc), 64'h100);
    clear_redirects();

    // Stall buffering: trap survives a later branch.
    stall = 1'b1;
    branch_addr_en = 1'b1; branch_addr = 32'h40;
    cycle("stl0");
    clear_redirects();
    trap_en = 1'b1; trap_addr = 32'h80;
    cycle("stl1");
    clear_redirects();
    branch_addr_en = 1'b1; branch_addr = 32'hC0;
    cycle("stl2");
    chk("stl_pend", 64'(pending_valid), 64'd1);
    chk("stl_pc", 64'(fetch_pc), 64'h100);
    clear_redirects();
    stall = 1'b0;
    cycle("stl3");
    chk("stl_rel_pc", 64'(fetch_pc), 64'h80);
    chk("stl_rel_pend", 64'(pending_valid), 64'd0);

    // Wrap at top of address space.
    fetch_req_ready = 1'b1;
    branch_addr_en = 1'b1; branch_addr = 32'hFFFF_FFFC;
    cycle("wrap0");
    clear_redirects();
    chk("wrap_add4_top", 64'(pc_add4), 64'h0);
    cycle("wrap1");
    chk("wrap_pc", 64'(fetch_pc), 64'h0);
    chk("wrap_add4", 64'(pc_add4), 64'h4);

    // Misaligned target.
    branch_addr_en = 1'b1; branch_addr = 32'h102;
    cycle("mis0");
    chk("mis_pulse", 64'(misalign_fault), 64'd1);
    chk("mis_addr", 64'(misalign_addr), 64'h102);
    chk("mis_valid", 64'(fetch_req_valid), 64'd0);
    chk("mis_pc", 64'(fetch_pc), 64'h0);
    branch_addr = 32'h200;
    cycle("mis1");
    chk("mis_ign_pc", 64'(fetch_pc), 64'h0);
    chk("mis_pulse_end", 64'(misalign_fault), 64'd0);
    clear_redirects();
    trap_en = 1'b1; trap_addr = 32'h300;
    cycle("mis2");
    chk("mis_trap_pc", 64'(fetch_pc), 64'h300);
    chk("mis_trap_valid", 64'(fetch_req_valid), 64'd1);
    clear_redirects();

    // Asynchronous reset during a stall with a pending redirect.
    stall = 1'b1;
    branch_addr_en = 1'b1; branch_addr = 32'h40;
    cycle("ar0");
    clear_redirects();
    chk("ar_pend_set", 64'(pending_valid), 64'd1);
    #2 nrst = 1'b0;
    #1;
    model_reset();
    chk("ar_pc", 64'(fetch_pc), 64'h0);
    chk("ar_pend", 64'(pending_valid), 64'd0);
    check_all("ar_now");
    stall = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    check_all("ar_boot");
    cycle("ar_run0");
    cycle("ar_run1");
    chk("ar_run1_pc", 64'(fetch_pc), 64'h4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      fetch_req_ready = 1'($urandom_range(0, 3) != 0);
      stall           = 1'($urandom_range(0, 3) == 0);
      trap_en         = 1'($urandom_range(0, 7) == 0);
      ret_en          = 1'($urandom_range(0, 7) == 0);
      branch_addr_en  = 1'($urandom_range(0, 4) == 0);
      trap_addr       = rand_addr();
      ret_addr        = rand_addr();
      branch_addr     = rand_addr();
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
